// File: rtl/pixel_tx_sequencer.sv
// pixel_tx_sequencer: serialises 24-bit pixels into three UART bytes with a per-frame SOF marker
// Tracks the raster position of the next pixel and pulses frame_done after the last byte of a frame.
module pixel_tx_sequencer #(
    parameter int         IMG_W      = 256,
    parameter int         IMG_H      = 256,
    parameter logic [7:0] SOF_BYTE   = 8'hA5,
    parameter bit         SEND_SOF   = 1'b1,
    parameter bit         BYTE_ORDER = 1'b0,
    localparam int        XW         = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int        YW         = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [23:0]   pix_in,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic          abort,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_done,
    output logic          busy
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SOF  = 3'd1;
    localparam logic [2:0] B0   = 3'd2;
    localparam logic [2:0] B1   = 3'd3;
    localparam logic [2:0] B2   = 3'd4;
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    logic [2:0]  state;
    logic [2:0]  nxt;
    logic [23:0] pix_reg;
    logic        last;
    logic [7:0]  first_byte;
    logic [7:0]  final_byte;
    logic        x_end;
    logic        y_end;

    assign pix_ready  = (state == IDLE) && !abort;
    assign tx_valid   = (state != IDLE);
    assign busy       = (state != IDLE);
    assign x_end      = (pix_x == X_MAX);
    assign y_end      = (pix_y == Y_MAX);
    assign first_byte = BYTE_ORDER ? pix_reg[7:0] : pix_reg[23:16];
    assign final_byte = BYTE_ORDER ? pix_reg[23:16] : pix_reg[7:0];

    always_comb begin
        nxt     = (state == SOF) ? B0 : (state == B0) ? B1 : (state == B1) ? B2 : IDLE;
        tx_data = (state == SOF) ? SOF_BYTE :
                  (state == B0)  ? first_byte :
                  (state == B1)  ? pix_reg[15:8] :
                  (state == B2)  ? final_byte : 8'h00;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pix_reg    <= '0;
            last       <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                if (abort) begin
                    pix_x <= '0;
                    pix_y <= '0;
                end else if (pix_valid) begin
                    pix_reg <= pix_in;
                    last    <= x_end && y_end;
                    state   <= (SEND_SOF && pix_x == '0 && pix_y == '0) ? SOF : B0;
                    pix_x   <= x_end ? '0 : pix_x + 1'b1;
                    pix_y   <= x_end ? (y_end ? '0 : pix_y + 1'b1) : pix_y;
                end
            end else if (tx_ready) begin
                // abort lets the byte on the wire finish, then drops the rest of the pixel
                if (abort) begin
                    state <= IDLE;
                    last  <= 1'b0;
                    pix_x <= '0;
                    pix_y <= '0;
                end else begin
                    state      <= nxt;
                    frame_done <= (state == B2) && last;
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_tx_sequencer.sv
// tb_pixel_tx_sequencer: two DUTs (byte orders 0 and 1) on shared stimulus, 4x2 frame.
// Expected bytes go into per-DUT queues; a negedge monitor pops and compares on each handshake.
module tb_pixel_tx_sequencer;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic        abort = 1'b0;
    logic        pr0, pr1, tv0, tv1, fd0, fd1, bz0, bz1;
    logic [7:0]  td0, td1;
    logic [1:0]  x0, x1;
    logic        y0, y1;
    int          checks = 0;
    int          errors = 0;
    int          fd_cnt0 = 0;
    int          fd_cnt1 = 0;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];

    always #5 clk = ~clk;

    pixel_tx_sequencer #(.IMG_W(4), .IMG_H(2), .SOF_BYTE(8'hA5), .SEND_SOF(1'b1), .BYTE_ORDER(1'b0)) u0 (
        .clk(clk), .resetn(resetn), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr0),
        .tx_data(td0), .tx_valid(tv0), .tx_ready(tx_ready), .abort(abort),
        .pix_x(x0), .pix_y(y0), .frame_done(fd0), .busy(bz0));

    pixel_tx_sequencer #(.IMG_W(4), .IMG_H(2), .SOF_BYTE(8'hA5), .SEND_SOF(1'b1), .BYTE_ORDER(1'b1)) u1 (
        .clk(clk), .resetn(resetn), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr1),
        .tx_data(td1), .tx_valid(tv1), .tx_ready(tx_ready), .abort(abort),
        .pix_x(x1), .pix_y(y1), .frame_done(fd1), .busy(bz1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (fd0) fd_cnt0++;
            if (fd1) fd_cnt1++;
            if (tv0 && tx_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL u0 byte: got %0h expected none", td0);
                end else begin
                    automatic logic [7:0] e = q0.pop_front();
                    if (td0 !== e) begin
                        errors++;
                        $display("FAIL u0 byte: got %0h expected %0h", td0, e);
                    end
                end
            end
            if (tv1 && tx_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL u1 byte: got %0h expected none", td1);
                end else begin
                    automatic logic [7:0] e = q1.pop_front();
                    if (td1 !== e) begin
                        errors++;
                        $display("FAIL u1 byte: got %0h expected %0h", td1, e);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pix(input logic [23:0] p, input bit sof);
        if (sof) begin
            q0.push_back(8'hA5);
            q1.push_back(8'hA5);
        end
        q0.push_back(p[23:16]); q0.push_back(p[15:8]); q0.push_back(p[7:0]);
        q1.push_back(p[7:0]);   q1.push_back(p[15:8]); q1.push_back(p[23:16]);
    endtask

    task automatic wait_idle;
        int n = 0;
        while (bz0 && n < 60) begin
            tick;
            n++;
        end
        if (bz0) begin
            errors++;
            $display("FAIL wait_idle: busy stuck at 1, required 0");
        end
    endtask

    task automatic send_pix(input logic [23:0] p, input bit sof, input bit done,
                            input logic [1:0] ex, input logic ey);
        int n = 0;
        while (!pr0 && n < 20) begin
            tick;
            n++;
        end
        expect_pix(p, sof);
        pix_in = p;
        pix_valid = 1'b1;
        tick;
        pix_valid = 1'b0;
        wait_idle;
        chk("frame_done0", 32'(fd0), 32'(done));
        chk("frame_done1", 32'(fd1), 32'(done));
        chk("pix_x", 32'(x0), 32'(ex));
        chk("pix_y", 32'(y0), 32'(ey));
    endtask

    initial begin
        tick;
        tick;
        chk("rst tx_valid", 32'(tv0), 0);
        chk("rst tx_data", 32'(td0), 0);
        chk("rst pix_x", 32'(x0), 0);
        chk("rst pix_y", 32'(y0), 0);
        chk("rst busy", 32'(bz0), 0);
        chk("rst frame_done", 32'(fd0), 0);
        resetn = 1'b1;
        tick;
        chk("pix_ready after reset", 32'(pr0), 1);
        send_pix(24'h112233, 1'b1, 1'b0, 2'd1, 1'b0);
        send_pix(24'h445566, 1'b0, 1'b0, 2'd2, 1'b0);
        // stall the middle byte for 10 cycles
        expect_pix(24'h112233, 1'b0);
        pix_in = 24'h112233;
        pix_valid = 1'b1;
        tick;
        pix_valid = 1'b0;
        pix_in = 24'hFFFFFF;
        tick;
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall tx_valid", 32'(tv0), 1);
            chk("stall tx_data0", 32'(td0), 32'h22);
            chk("stall tx_data1", 32'(td1), 32'h22);
            tick;
        end
        tx_ready = 1'b1;
        wait_idle;
        chk("pix_x after stall", 32'(x0), 3);
        send_pix(24'h010203, 1'b0, 1'b0, 2'd0, 1'b1);
        send_pix(24'h040506, 1'b0, 1'b0, 2'd1, 1'b1);
        send_pix(24'h070809, 1'b0, 1'b0, 2'd2, 1'b1);
        send_pix(24'h0A0B0C, 1'b0, 1'b0, 2'd3, 1'b1);
        send_pix(24'hC0FFEE, 1'b0, 1'b1, 2'd0, 1'b0);
        tick;
        chk("frame_done single pulse", 32'(fd0), 0);
        send_pix(24'hDEADBE, 1'b1, 1'b0, 2'd1, 1'b0);
        // abort while the middle byte waits: only first two bytes go out
        q0.push_back(8'hAB); q0.push_back(8'hCD);
        q1.push_back(8'hEF); q1.push_back(8'hCD);
        pix_in = 24'hABCDEF;
        pix_valid = 1'b1;
        tick;
        pix_valid = 1'b0;
        tick;
        tx_ready = 1'b0;
        tick;
        abort = 1'b1;
        tick;
        chk("abort hold tx_valid", 32'(tv0), 1);
        chk("abort hold tx_data", 32'(td0), 32'hCD);
        tx_ready = 1'b1;
        tick;
        chk("abort busy", 32'(bz0), 0);
        chk("abort pix_ready", 32'(pr0), 0);
        chk("abort pix_x", 32'(x0), 0);
        chk("abort pix_y", 32'(y0), 0);
        chk("abort frame_done", 32'(fd0), 0);
        abort = 1'b0;
        #1;
        chk("pix_ready after abort", 32'(pr0), 1);
        send_pix(24'h123456, 1'b1, 1'b0, 2'd1, 1'b0);
        // reset while the first byte is pending
        tx_ready = 1'b0;
        pix_in = 24'h999999;
        pix_valid = 1'b1;
        tick;
        pix_valid = 1'b0;
        chk("pre-reset tx_valid", 32'(tv0), 1);
        resetn = 1'b0;
        #1;
        chk("reset tx_valid", 32'(tv0), 0);
        chk("reset busy", 32'(bz0), 0);
        chk("reset pix_x", 32'(x0), 0);
        tick;
        resetn = 1'b1;
        tx_ready = 1'b1;
        tick;
        chk("pix_ready after mid reset", 32'(pr0), 1);
        send_pix(24'h0055AA, 1'b1, 1'b0, 2'd1, 1'b0);
        tick;
        chk("u0 queue drained", 32'(q0.size()), 0);
        chk("u1 queue drained", 32'(q1.size()), 0);
        chk("u0 frame_done count", 32'(fd_cnt0), 1);
        chk("u1 frame_done count", 32'(fd_cnt1), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
